// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter slice.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE      = 1'b0,
    ARB_RMW_MERGE = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_owner_t;

  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/mem_arbiter_byte_merger.sv
// Byte-lane merge: enabled lanes come from the new word, the rest from the old word.
module byte_merger #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);

  // Select each byte lane independently from old or new data.
  always_comb begin
    merged = old_word;
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (be[i]) begin
        merged[i*8 +: 8] = new_word[i*8 +: 8];
      end else begin
        merged[i*8 +: 8] = old_word[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data-priority grants with bounded fetch
// starvation, read-data routing to the owner, and read-modify-write for
// partial stores.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = 10,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_GNT,
  output logic              IF_RVALID,
  output logic [DATA_W-1:0] IF_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  input  logic [3:0]        D_BYTE_EN,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [DATA_W-1:0] D_RDATA,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic              MEM_WRITE_ENABLE,
  output logic [DATA_W-1:0] MEM_WRITE_DATA,
  input  logic [DATA_W-1:0] MEM_READ_DATA,
  output logic              BUSY
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state_t          state;
  arb_owner_t          owner;
  logic [STREAK_W-1:0] streak;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [3:0]          lat_be;
  logic [ADDR_W-1:0]   last_addr;
  logic [DATA_W-1:0]   last_wdata;

  logic                if_gnt_s;
  logic                d_gnt_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic                mem_we_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic [DATA_W-1:0]   merged_s;
  logic                partial_s;

  // Latched store data overlays the word read back during the grant cycle.
  byte_merger #(.DATA_W(DATA_W)) u_merge (
    .old_word (MEM_READ_DATA),
    .new_word (lat_wdata),
    .be       (lat_be),
    .merged   (merged_s)
  );

  assign partial_s = D_WE && (D_BYTE_EN != BE_FULL) && (D_BYTE_EN != BE_NONE);

  // Grant selection and memory command; address/wdata hold when idle.
  always_comb begin
    if_gnt_s    = 1'b0;
    d_gnt_s     = 1'b0;
    mem_addr_s  = last_addr;
    mem_we_s    = 1'b0;
    mem_wdata_s = last_wdata;
    if (!RSTN) begin
      if_gnt_s = 1'b0;
    end else if (state == ARB_RMW_MERGE) begin
      mem_addr_s  = lat_addr;
      mem_we_s    = 1'b1;
      mem_wdata_s = merged_s;
    end else if (D_REQ && !(IF_REQ && (streak == STREAK_MAX))) begin
      d_gnt_s = 1'b1;
      if (!D_WE) begin
        mem_addr_s = D_ADDR;
      end else if (D_BYTE_EN == BE_FULL) begin
        mem_addr_s  = D_ADDR;
        mem_wdata_s = D_WDATA;
        mem_we_s    = 1'b1;
      end else if (D_BYTE_EN != BE_NONE) begin
        mem_addr_s = D_ADDR;
      end else begin
        mem_addr_s = last_addr;
      end
    end else if (IF_REQ) begin
      if_gnt_s   = 1'b1;
      mem_addr_s = IF_ADDR;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Arbiter state, starvation counter, read owner and RMW latches.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= ARB_IDLE;
      owner      <= NONE;
      streak     <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= 4'b0000;
      last_addr  <= '0;
      last_wdata <= '0;
    end else begin
      last_addr  <= mem_addr_s;
      last_wdata <= mem_wdata_s;

      if (if_gnt_s) begin
        owner <= FETCH;
      end else if (d_gnt_s && !D_WE) begin
        owner <= DATA;
      end else begin
        owner <= NONE;
      end

      if (!IF_REQ || if_gnt_s) begin
        streak <= '0;
      end else if (d_gnt_s && (streak != STREAK_MAX)) begin
        streak <= streak + STREAK_W'(1);
      end else begin
        streak <= streak;
      end

      case (state)
        ARB_IDLE: begin
          if (d_gnt_s && partial_s) begin
            state     <= ARB_RMW_MERGE;
            lat_addr  <= D_ADDR;
            lat_wdata <= D_WDATA;
            lat_be    <= D_BYTE_EN;
          end else begin
            state <= ARB_IDLE;
          end
        end
        ARB_RMW_MERGE: state <= ARB_IDLE;
        default:       state <= ARB_IDLE;
      endcase
    end
  end

  assign IF_GNT           = if_gnt_s;
  assign D_GNT            = d_gnt_s;
  assign IF_RVALID        = (owner == FETCH);
  assign D_RVALID         = (owner == DATA);
  assign IF_RDATA         = (owner == FETCH) ? MEM_READ_DATA : '0;
  assign D_RDATA          = (owner == DATA) ? MEM_READ_DATA : '0;
  assign MEM_ADDRESS      = mem_addr_s;
  assign MEM_WRITE_ENABLE = mem_we_s;
  assign MEM_WRITE_DATA   = mem_wdata_s;
  assign BUSY             = (state == ARB_RMW_MERGE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency word memory model.
module tb_mem_arbiter;

  logic        CLK;
  logic        RSTN;
  logic        IF_REQ;
  logic [9:0]  IF_ADDR;
  logic        IF_GNT;
  logic        IF_RVALID;
  logic [31:0] IF_RDATA;
  logic        D_REQ;
  logic        D_WE;
  logic [9:0]  D_ADDR;
  logic [31:0] D_WDATA;
  logic [3:0]  D_BYTE_EN;
  logic        D_GNT;
  logic        D_RVALID;
  logic [31:0] D_RDATA;
  logic [9:0]  MEM_ADDRESS;
  logic        MEM_WRITE_ENABLE;
  logic [31:0] MEM_WRITE_DATA;
  logic [31:0] MEM_READ_DATA;
  logic        BUSY;

  logic [31:0] mem [0:1023];
  int          n_checks;
  int          n_fail;

  mem_arbiter dut (
    .CLK              (CLK),
    .RSTN             (RSTN),
    .IF_REQ           (IF_REQ),
    .IF_ADDR          (IF_ADDR),
    .IF_GNT           (IF_GNT),
    .IF_RVALID        (IF_RVALID),
    .IF_RDATA         (IF_RDATA),
    .D_REQ            (D_REQ),
    .D_WE             (D_WE),
    .D_ADDR           (D_ADDR),
    .D_WDATA          (D_WDATA),
    .D_BYTE_EN        (D_BYTE_EN),
    .D_GNT            (D_GNT),
    .D_RVALID         (D_RVALID),
    .D_RDATA          (D_RDATA),
    .MEM_ADDRESS      (MEM_ADDRESS),
    .MEM_WRITE_ENABLE (MEM_WRITE_ENABLE),
    .MEM_WRITE_DATA   (MEM_WRITE_DATA),
    .MEM_READ_DATA    (MEM_READ_DATA),
    .BUSY             (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Synchronous word memory: read data appears one cycle after the address.
  always @(posedge CLK) begin
    if (MEM_WRITE_ENABLE) mem[MEM_ADDRESS] <= MEM_WRITE_DATA;
    MEM_READ_DATA <= mem[MEM_ADDRESS];
  end

  task automatic next_cycle;
    @(posedge CLK);
    #1;
  endtask

  task automatic full_store(input logic [9:0] a, input logic [31:0] d);
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = a; D_WDATA = d; D_BYTE_EN = 4'b1111;
    next_cycle();
    D_REQ = 1'b0; D_WE = 1'b0; D_BYTE_EN = 4'b0000;
  endtask

  task automatic test_reset;
    RSTN = 1'b0; IF_REQ = 1'b1; D_REQ = 1'b1; D_WE = 1'b0;
    IF_ADDR = 10'd0; D_ADDR = 10'd0; D_WDATA = 32'd0; D_BYTE_EN = 4'b0000;
    @(negedge CLK);
    n_checks++;
    if (IF_GNT !== 1'b0 || D_GNT !== 1'b0) begin
      n_fail++; $display("FAIL rst_gnt: got if=%b d=%b want 0 0", IF_GNT, D_GNT);
    end
    n_checks++;
    if (IF_RVALID !== 1'b0 || D_RVALID !== 1'b0 || IF_RDATA !== 32'd0 || D_RDATA !== 32'd0) begin
      n_fail++; $display("FAIL rst_rd: got %b %b %h %h want 0 0 0 0", IF_RVALID, D_RVALID, IF_RDATA, D_RDATA);
    end
    n_checks++;
    if (BUSY !== 1'b0 || MEM_WRITE_ENABLE !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy_we: got %b %b want 0 0", BUSY, MEM_WRITE_ENABLE);
    end
    next_cycle();
    RSTN = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (D_GNT !== 1'b1 || IF_GNT !== 1'b0) begin
      n_fail++; $display("FAIL rst_first_gnt: got d=%b if=%b want 1 0", D_GNT, IF_GNT);
    end
    next_cycle();
    IF_REQ = 1'b0; D_REQ = 1'b0;
    next_cycle();
  endtask

  task automatic test_store_load;
    int we_cnt;
    we_cnt = 0;
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 10'd7; D_WDATA = 32'hCAFEF00D; D_BYTE_EN = 4'b1111;
    @(negedge CLK);
    if (MEM_WRITE_ENABLE === 1'b1) we_cnt++;
    n_checks++;
    if (D_GNT !== 1'b1 || MEM_ADDRESS !== 10'd7 || MEM_WRITE_DATA !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL st_cmd: got gnt=%b a=%0d wd=%h want 1 7 cafef00d", D_GNT, MEM_ADDRESS, MEM_WRITE_DATA);
    end
    next_cycle();
    D_WE = 1'b0; D_BYTE_EN = 4'b0000;
    @(negedge CLK);
    if (MEM_WRITE_ENABLE === 1'b1) we_cnt++;
    n_checks++;
    if (D_GNT !== 1'b1 || D_RVALID !== 1'b0) begin
      n_fail++; $display("FAIL ld_gnt: got gnt=%b rv=%b want 1 0", D_GNT, D_RVALID);
    end
    next_cycle();
    D_REQ = 1'b0;
    @(negedge CLK);
    if (MEM_WRITE_ENABLE === 1'b1) we_cnt++;
    n_checks++;
    if (D_RVALID !== 1'b1 || D_RDATA !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL ld_data: got rv=%b %h want 1 cafef00d", D_RVALID, D_RDATA);
    end
    n_checks++;
    if (we_cnt != 1) begin
      n_fail++; $display("FAIL st_we_cycles: got %0d want 1", we_cnt);
    end
    next_cycle();
  endtask

  task automatic test_fetch;
    full_store(10'd5, 32'hDEADBEEF);
    IF_REQ = 1'b1; IF_ADDR = 10'd5;
    @(negedge CLK);
    n_checks++;
    if (IF_GNT !== 1'b1 || D_GNT !== 1'b0 || MEM_WRITE_ENABLE !== 1'b0 || MEM_ADDRESS !== 10'd5) begin
      n_fail++; $display("FAIL f_gnt: got if=%b d=%b we=%b a=%0d want 1 0 0 5", IF_GNT, D_GNT, MEM_WRITE_ENABLE, MEM_ADDRESS);
    end
    next_cycle();
    IF_REQ = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (IF_RVALID !== 1'b1 || IF_RDATA !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL f_data: got rv=%b %h want 1 deadbeef", IF_RVALID, IF_RDATA);
    end
    n_checks++;
    if (D_RVALID !== 1'b0 || D_RDATA !== 32'd0) begin
      n_fail++; $display("FAIL f_drv: got rv=%b %h want 0 0", D_RVALID, D_RDATA);
    end
    next_cycle();
    @(negedge CLK);
    n_checks++;
    if (IF_RVALID !== 1'b0 || IF_RDATA !== 32'd0) begin
      n_fail++; $display("FAIL f_rv_drop: got rv=%b %h want 0 0", IF_RVALID, IF_RDATA);
    end
    next_cycle();
  endtask

  task automatic test_arbitration;
    logic exp_f;
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 10'd0; IF_REQ = 1'b1; IF_ADDR = 10'd1;
    for (int i = 0; i < 10; i++) begin
      exp_f = ((i % 5) == 4);
      @(negedge CLK);
      n_checks++;
      if (IF_GNT !== exp_f || D_GNT !== !exp_f) begin
        n_fail++; $display("FAIL arb_slot%0d: got if=%b d=%b want if=%b d=%b", i, IF_GNT, D_GNT, exp_f, !exp_f);
      end
      next_cycle();
    end
    D_REQ = 1'b0; IF_REQ = 1'b0;
    next_cycle();
  endtask

  task automatic test_empty_store;
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 10'd5; D_WDATA = 32'h12345678; D_BYTE_EN = 4'b0000;
    @(negedge CLK);
    n_checks++;
    if (D_GNT !== 1'b1 || MEM_WRITE_ENABLE !== 1'b0) begin
      n_fail++; $display("FAIL be0_cmd: got gnt=%b we=%b want 1 0", D_GNT, MEM_WRITE_ENABLE);
    end
    next_cycle();
    D_REQ = 1'b0; D_WE = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (D_RVALID !== 1'b0 || BUSY !== 1'b0 || MEM_WRITE_ENABLE !== 1'b0) begin
      n_fail++; $display("FAIL be0_after: got rv=%b busy=%b we=%b want 0 0 0", D_RVALID, BUSY, MEM_WRITE_ENABLE);
    end
    next_cycle();
  endtask

  task automatic test_partial_store;
    full_store(10'd3, 32'h11223344);
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 10'd3; D_WDATA = 32'h0000AA00; D_BYTE_EN = 4'b0010;
    @(negedge CLK);
    n_checks++;
    if (D_GNT !== 1'b1 || MEM_WRITE_ENABLE !== 1'b0 || MEM_ADDRESS !== 10'd3 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL rmw_rd: got gnt=%b we=%b a=%0d busy=%b want 1 0 3 0", D_GNT, MEM_WRITE_ENABLE, MEM_ADDRESS, BUSY);
    end
    next_cycle();
    D_WE = 1'b0; D_BYTE_EN = 4'b0000; D_WDATA = 32'd0; IF_REQ = 1'b1; IF_ADDR = 10'd2;
    @(negedge CLK);
    n_checks++;
    if (BUSY !== 1'b1 || IF_GNT !== 1'b0 || D_GNT !== 1'b0) begin
      n_fail++; $display("FAIL rmw_busy: got busy=%b if=%b d=%b want 1 0 0", BUSY, IF_GNT, D_GNT);
    end
    n_checks++;
    if (MEM_WRITE_ENABLE !== 1'b1 || MEM_ADDRESS !== 10'd3 || MEM_WRITE_DATA !== 32'h1122AA44) begin
      n_fail++; $display("FAIL rmw_wr: got we=%b a=%0d wd=%h want 1 3 1122aa44", MEM_WRITE_ENABLE, MEM_ADDRESS, MEM_WRITE_DATA);
    end
    next_cycle();
    IF_REQ = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (D_GNT !== 1'b1 || BUSY !== 1'b0 || MEM_WRITE_ENABLE !== 1'b0) begin
      n_fail++; $display("FAIL rmw_ld_gnt: got gnt=%b busy=%b we=%b want 1 0 0", D_GNT, BUSY, MEM_WRITE_ENABLE);
    end
    next_cycle();
    D_REQ = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (D_RVALID !== 1'b1 || D_RDATA !== 32'h1122AA44) begin
      n_fail++; $display("FAIL rmw_ld_data: got rv=%b %h want 1 1122aa44", D_RVALID, D_RDATA);
    end
    next_cycle();
  endtask

  task automatic test_reset_in_merge;
    full_store(10'd9, 32'h01020304);
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 10'd9; D_WDATA = 32'hAABB0000; D_BYTE_EN = 4'b1100;
    next_cycle();
    D_REQ = 1'b0; D_WE = 1'b0; D_BYTE_EN = 4'b0000;
    n_checks++;
    if (BUSY !== 1'b1) begin
      n_fail++; $display("FAIL rim_busy: got %b want 1", BUSY);
    end
    #2;
    RSTN = 1'b0;
    #1;
    n_checks++;
    if (BUSY !== 1'b0 || MEM_WRITE_ENABLE !== 1'b0) begin
      n_fail++; $display("FAIL rim_abort: got busy=%b we=%b want 0 0", BUSY, MEM_WRITE_ENABLE);
    end
    next_cycle();
    RSTN = 1'b1;
    next_cycle();
    D_REQ = 1'b1; D_ADDR = 10'd9;
    @(negedge CLK);
    n_checks++;
    if (D_GNT !== 1'b1) begin
      n_fail++; $display("FAIL rim_ld_gnt: got %b want 1", D_GNT);
    end
    next_cycle();
    D_REQ = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (D_RVALID !== 1'b1 || D_RDATA !== 32'h01020304) begin
      n_fail++; $display("FAIL rim_data: got rv=%b %h want 1 01020304", D_RVALID, D_RDATA);
    end
    next_cycle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_store_load();
    test_fetch();
    test_arbitration();
    test_empty_store();
    test_partial_store();
    test_reset_in_merge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and sequencer that shares the core's word-addressed `block_memory` between the instruction-fetch port and the execute-stage load/store port. It grants one requester per cycle, with data priority and bounded fetch starvation. It routes the one-cycle-latency read data back to the owner. It turns partial stores (sb/sh) into a read-modify-write sequence, because the memory only writes full words. It sits between the fetch unit / executer and `block_memory`.

## Interface
- `ADDR_W`, 10, word address width.
- `DATA_W`, 32, data word width.
- `MAX_DATA_STREAK`, 4, maximum consecutive data grants while fetch waits.

- `CLK`  in  1  sole clock, all state on rising edge.
- `RSTN`  in  1  reset, asynchronous, active-low.
- `IF_REQ`  in  1  fetch read request; held until granted.
- `IF_ADDR`  in  ADDR_W  fetch word address.
- `IF_GNT`  out  1  fetch request accepted this cycle (combinational).
- `IF_RVALID`  out  1  fetch read data valid.
- `IF_RDATA`  out  DATA_W  fetch read data; 0 when `IF_RVALID`=0.
- `D_REQ`  in  1  data request; held with all `D_*` stable until granted.
- `D_WE`  in  1  1 = store, 0 = load.
- `D_ADDR`  in  ADDR_W  data word address.
- `D_WDATA`  in  DATA_W  store data, lane-aligned.
- `D_BYTE_EN`  in  4  store byte lanes; ignored for loads.
- `D_GNT`  out  1  data request accepted this cycle (combinational).
- `D_RVALID`  out  1  load data valid.
- `D_RDATA`  out  DATA_W  load data; 0 when `D_RVALID`=0.
- `MEM_ADDRESS`  out  ADDR_W  to memory.
- `MEM_WRITE_ENABLE`  out  1  to memory.
- `MEM_WRITE_DATA`  out  DATA_W  to memory.
- `MEM_READ_DATA`  in  DATA_W  from memory, valid one cycle after its address.
- `BUSY`  out  1  RMW merge cycle in progress; no grants.

## Operation
- The FSM has two states: `ARB_IDLE` and `ARB_RMW_MERGE`.
- In `ARB_IDLE`, at most one grant per cycle:
  - Data wins unless `IF_REQ`=1 and the streak counter = `MAX_DATA_STREAK`; in that case fetch wins.
  - The streak counter increments on each data grant while `IF_REQ`=1 and saturates at `MAX_DATA_STREAK`.
  - The counter clears on a fetch grant, or on any cycle with `IF_REQ`=0.
- Fetch grant:
  - Drive `MEM_ADDRESS`=`IF_ADDR` with WE=0.
  - Owner tag FETCH is registered, so `IF_RVALID`=1 on the next cycle.
- Load grant: same as a fetch grant, with owner DATA, so `D_RVALID`=1 on the next cycle.
- Full store (`D_BYTE_EN`=4'b1111):
  - Drive addr and wdata with WE=1, for one cycle only.
  - No RVALID.
- Store with `D_BYTE_EN`=0: granted, no memory access, no RVALID, counted in the streak.
- Partial store (any other BE):
  - Grant cycle: issue a read of `D_ADDR` (WE=0) and latch addr, wdata and BE. Next state is `ARB_RMW_MERGE`.
  - `ARB_RMW_MERGE` cycle: write merged word = enabled lanes from latched wdata, other lanes from `MEM_READ_DATA`, to the latched addr with WE=1.
  - `IF_GNT`=`D_GNT`=0 and `BUSY`=1 during this cycle. Next state is `ARB_IDLE`.
- When nothing is granted, `MEM_WRITE_ENABLE`=0. `MEM_ADDRESS`/`MEM_WRITE_DATA` hold their last values.
- Reset values:
  - state `ARB_IDLE`, streak 0, owner NONE.
  - `IF_RVALID`=`D_RVALID`=0, RDATA outputs 0, `BUSY`=0, `MEM_WRITE_ENABLE`=0, grants 0.
- Reset asserted during `ARB_RMW_MERGE`: the merge write is abandoned and memory is unchanged. After release, the store must be re-requested.

## Timing
- Grants are combinational from the requests and the registered state. A request completes on the cycle where REQ & GNT.
- Read latency: grant in cycle N, RVALID/RDATA in N+1. Back-to-back reads run at one per cycle.
- Full store occupies 1 cycle. Partial store occupies 2 cycles; the next grant is possible in N+2.
- A fetch waits at most `MAX_DATA_STREAK`+1 grant slots. An RMW counts as one slot plus its merge cycle.
- A load issued in N+2 to the partial-store address returns the merged word.

## Structure
- Package `mem_arb_pkg` holds:
  - `arb_state_t` enum {`ARB_IDLE`, `ARB_RMW_MERGE`}.
  - `arb_owner_t` enum {NONE, FETCH, DATA}.
  - Constant `BE_FULL`=4'b1111.
- Sub-module `byte_merger`: combinational lane merge (old word, new word, BE → merged word). It is instantiated once.

## Test plan
- Reset with `IF_REQ`=1, `D_REQ`=1 held: all outputs match the reset values while `RSTN`=0. After release, `D_GNT`=1 on the first cycle.
- Mem[5]=0xDEADBEEF; fetch at address 5 → `IF_GNT` in N, `IF_RVALID`=1 with `IF_RDATA`=0xDEADBEEF in N+1, `D_RVALID`=0.
- `D_REQ` and `IF_REQ` held continuously → 4 data grants, then 1 fetch grant, repeating 4:1.
- Mem[3]=0x11223344; sb with BE=4'b0010 and wdata=0x0000AA00 → `BUSY`=1 in N+1 and no grants. A load of address 3 in N+2 returns 0x1122AA44.
- Full store of 0xCAFEF00D to address 7, then a load of address 7 the next cycle → `D_RDATA`=0xCAFEF00D and `MEM_WRITE_ENABLE` high for exactly 1 cycle.
- `RSTN` pulsed low during `ARB_RMW_MERGE` of sh BE=4'b1100 to address 9 (mem 0x01020304) → a later load of address 9 returns 0x01020304.
